sdnf_scanner: RTL and testbench
===============================

# sdnf_scanner

Sequential truth-table extractor, the inverse of a sum-of-minterms function block. It drives every input combination into an external N-input combinational function and samples its single-bit output. It builds the minterm mask and minterm count, then streams the index of each minterm in ascending order over a valid/ready handshake. It sits beside any sdnf-style function block and recovers its perfect disjunctive normal form for checking and documentation.

## Interface
- N, default 5: number of function inputs; 2^N combinations scanned.
- SETTLE, default 1 (range 1..15): clock cycles each combination is held on `fn_in` before `fn_out` is sampled.

Ports:
- `clk`  in  1: single clock, all state on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: begin a scan; sampled only in IDLE.
- `busy`  out  1: high in every state except IDLE.
- `fn_in`  out  N: registered input vector driven to the function under test.
- `fn_out`  in  1: function output, combinational from `fn_in`.
- `mask`  out  2^N: bit k = f(k); `mask[k]` is written when combination k is sampled.
- `count`  out  N+1: number of set mask bits (0..2^N).
- `m_valid`  out  1: minterm index available.
- `m_index`  out  N: minterm index; stable while `m_valid` && !`m_ready`.
- `m_ready`  in  1: consumer accepts the index when high together with `m_valid`.
- `done`  out  1: one-cycle pulse at the end of the operation.

## Operation
- States: IDLE, SCAN, EMIT, FIN.
- IDLE: `start`=1 clears `mask` and `count`, loads `fn_in`=0 and the settle counter = SETTLE-1, then goes to SCAN.
- SCAN: hold `fn_in` until the settle counter reaches 0. On that edge:
  - write `mask[fn_in]` = `fn_out`;
  - increment `count` if `fn_out`=1;
  - increment `fn_in` and reload the settle counter.
- SCAN exit: after sampling index 2^N-1, `fn_in` wraps to 0. Go to EMIT if `count` (including this sample) is nonzero, else go to FIN.
- EMIT: pointer `p` starts at 0 and steps once per cycle.
  - If `mask[p]`=0: advance `p`.
  - If `mask[p]`=1: assert `m_valid`, `m_index`=p, and hold until `m_ready`=1, then advance `p`.
  - After `p`=2^N-1 is handled, go to FIN.
- FIN: `done`=1 for exactly one cycle, then go to IDLE. `mask` and `count` are retained until the next `start`.
- `start` in any state other than IDLE is ignored.
- `m_ready` outside a valid cycle is ignored.
- `count` saturates only by construction; it reaches at most 2^N and needs no wrap handling.
- `rst` at any time, including mid-scan or mid-handshake, forces IDLE and clears all outputs, `mask` and `count`. Any index being offered is dropped.

## Timing
- Reset values: `busy`=0, `fn_in`=0, `mask`=0, `count`=0, `m_valid`=0, `m_index`=0, `done`=0.
- Start edge: `start` is sampled at edge 0. `busy`=1 and `fn_in`=0 from cycle 1.
- Scan sampling: combination k is presented during cycles 1+k·SETTLE .. (k+1)·SETTLE and sampled on the last edge of that window.
- Scan duration is exactly 2^N·SETTLE cycles; the first EMIT or FIN cycle is 1+2^N·SETTLE.
- `mask`/`count` update one edge after their sample; they are visible the following cycle.
- EMIT takes 2^N cycles plus one stall cycle per cycle `m_valid`=1 && `m_ready`=0.
- With `m_ready` held at 1, each minterm costs exactly one cycle.
- `m_valid` is registered and is never deasserted without acceptance, except by reset.
- `done` is asserted the cycle after the final EMIT step (or after the scan if `count`=0). `busy` falls the cycle after `done`.

## Test plan
- 5-input function with minterms {2,6,7,9,11,13,14,16,18,19,20,22,23,24..31}, SETTLE=1, `m_ready`=1 -> `mask`=0xFFDD6AC4 and `count`=21. Indices 2,6,7,9,11,13,14,16,18,19,20,22,23,24,...,31 are emitted in order. `done` pulses at cycle 1+32+32.
- Constant-0 function -> `mask`=0, `count`=0, `m_valid` never asserted. `done` pulses at cycle 33.
- Constant-1 function, SETTLE=3, `m_ready` toggling 1/0 -> `count`=32. Indices 0..31 are each accepted exactly once, and `m_index` is stable during stalls.
- `start` pulsed repeatedly while `busy` -> no restart, results identical to a single start.
- `rst` asserted at cycle 10 of a scan -> next cycle all outputs are 0 and the state is IDLE. A fresh `start` then produces the full correct mask.
- `rst` asserted while `m_valid`=1 and `m_ready`=0 -> `m_valid`=0 the next cycle and no `done` pulse.

Source files
------------

// File: rtl/sdnf_scanner_if.sv
// Minterm index stream: producer offers an index, consumer accepts with m_ready.
interface sdnf_scanner_if #(
  parameter int N = 5
);
  logic         m_valid;
  logic [N-1:0] m_index;
  logic         m_ready;

  modport master (output m_valid, m_index, input m_ready);
  modport slave  (input m_valid, m_index, output m_ready);
endinterface

// File: rtl/sdnf_scanner.sv
// Truth-table extractor: sweeps every input combination through an external
// N-input function, records the minterm mask/count and streams minterm indices.
module sdnf_scanner #(
  parameter int N      = 5,
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic [N-1:0]      fn_in,
  input  logic              fn_out,
  output logic [(1<<N)-1:0] mask,
  output logic [N:0]        count,
  sdnf_scanner_if.master    m,
  output logic              done
);

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE - 1);

  typedef enum logic [1:0] {IDLE, SCAN, EMIT, FIN} state_t;

  state_t       state, state_next;
  logic [3:0]   settle;
  logic [N-1:0] p;
  logic [N-1:0] p_nxt;
  logic         m_valid_r;
  logic [N:0]   count_inc;
  logic         load, sample, settle_dec, advance;

  assign p_nxt     = p + N'(1);
  assign count_inc = count + {{N{1'b0}}, fn_out};
  assign m.m_valid = m_valid_r;
  assign m.m_index = p;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    sample     = 1'b0;
    settle_dec = 1'b0;
    advance    = 1'b0;
    busy       = (state != IDLE);
    done       = (state == FIN);
    case (state)
      IDLE: if (start) begin
        load       = 1'b1;
        state_next = SCAN;
      end
      SCAN: if (settle == 4'd0) begin
        sample = 1'b1;
        if (&fn_in) state_next = (count_inc != '0) ? EMIT : FIN;
      end else begin
        settle_dec = 1'b1;
      end
      // A slot is consumed when nothing is offered or the offer is taken.
      EMIT: if (!m_valid_r || m.m_ready) begin
        advance = 1'b1;
        if (&p) state_next = FIN;
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fn_in     <= '0;
      mask      <= '0;
      count     <= '0;
      settle    <= '0;
      p         <= '0;
      m_valid_r <= 1'b0;
    end else if (load) begin
      fn_in     <= '0;
      mask      <= '0;
      count     <= '0;
      settle    <= SETTLE_LD;
      p         <= '0;
      m_valid_r <= 1'b0;
    end else if (sample) begin
      mask[fn_in] <= fn_out;
      count       <= count_inc;
      fn_in       <= fn_in + N'(1);
      settle      <= SETTLE_LD;
      // The emit pointer is primed so index 0 is offered on the first EMIT cycle.
      if ((&fn_in) && (count_inc != '0)) begin
        p         <= '0;
        m_valid_r <= mask[0];
      end
    end else if (settle_dec) begin
      settle <= settle - 4'd1;
    end else if (advance) begin
      if (&p) begin
        m_valid_r <= 1'b0;
      end else begin
        p         <= p_nxt;
        m_valid_r <= mask[p_nxt];
      end
    end
  end

endmodule

// File: tb/tb_sdnf_scanner.sv
// Bench for sdnf_scanner: two instances (SETTLE=1 and SETTLE=3) driven by
// table-defined functions, compared against a truth-table reference model.
module tb_sdnf_scanner;
  localparam int N = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a [2];
  logic        rdy_a   [2];
  logic [31:0] truth_a [2];

  logic        busy_0, busy_1, done_0, done_1;
  logic [4:0]  fn_in_0, fn_in_1;
  logic [31:0] mask_0, mask_1;
  logic [5:0]  count_0, count_1;
  logic        fo_0, fo_1;

  sdnf_scanner_if #(.N(N)) mif0 ();
  sdnf_scanner_if #(.N(N)) mif1 ();

  assign mif0.m_ready = rdy_a[0];
  assign mif1.m_ready = rdy_a[1];
  assign fo_0 = truth_a[0][fn_in_0];
  assign fo_1 = truth_a[1][fn_in_1];

  sdnf_scanner #(.N(N), .SETTLE(1)) dut0 (
    .clk(clk), .rst(rst), .start(start_a[0]), .busy(busy_0), .fn_in(fn_in_0),
    .fn_out(fo_0), .mask(mask_0), .count(count_0), .m(mif0), .done(done_0)
  );

  sdnf_scanner #(.N(N), .SETTLE(3)) dut1 (
    .clk(clk), .rst(rst), .start(start_a[1]), .busy(busy_1), .fn_in(fn_in_1),
    .fn_out(fo_1), .mask(mask_1), .count(count_1), .m(mif1), .done(done_1)
  );

  always #5 clk = ~clk;

  // Observation mux onto the instance currently under test
  int          sel = 0;
  logic        o_busy, o_done, o_valid;
  logic [4:0]  o_fn_in, o_index;
  logic [31:0] o_mask;
  logic [5:0]  o_count;

  always_comb begin
    if (sel == 1) begin
      o_busy = busy_1; o_done = done_1; o_valid = mif1.m_valid; o_index = mif1.m_index;
      o_fn_in = fn_in_1; o_mask = mask_1; o_count = count_1;
    end else begin
      o_busy = busy_0; o_done = done_0; o_valid = mif0.m_valid; o_index = mif0.m_index;
      o_fn_in = fn_in_0; o_mask = mask_0; o_count = count_0;
    end
  end

  int checks = 0;
  int errors = 0;

  // Results of the last run_scan
  int   r_idx[$];
  int   r_done_cyc, r_stalls, r_stab_err, r_fn_err, r_valid_seen;
  bit   r_timeout;
  logic r_busy_after, r_done_after;

  function automatic int popc(input logic [31:0] t);
    int c = 0;
    for (int k = 0; k < 32; k++) if (t[k]) c++;
    return c;
  endfunction

  // Reference: minterm indices of t in ascending order vs. accepted indices.
  function automatic int list_mismatch(input logic [31:0] t);
    int exp_q[$];
    int bad = 0;
    for (int k = 0; k < 32; k++) if (t[k]) exp_q.push_back(k);
    if (exp_q.size() != r_idx.size()) return 1000 + r_idx.size();
    for (int k = 0; k < exp_q.size(); k++) if (exp_q[k] != r_idx[k]) bad++;
    return bad;
  endfunction

  function automatic int exp_done(input logic [31:0] t, input int s, input int stalls);
    if (t == 32'h0) return 1 + 32 * s;
    return 1 + 32 * s + 32 + stalls;
  endfunction

  // Starts a scan on instance w and records everything up to one cycle past done.
  task automatic run_scan(input int w, input logic [31:0] t, input int rmode,
                          input bit extra_start, input int s);
    int   cyc;
    logic r;
    bit   held_v;
    logic [4:0] held_i;
    sel = w; truth_a[w] = t; r_idx.delete();
    r_done_cyc = -1; r_stalls = 0; r_stab_err = 0; r_fn_err = 0;
    r_valid_seen = 0; r_timeout = 0; held_v = 0; held_i = '0;
    @(negedge clk); start_a[w] = 1'b1; rdy_a[w] = 1'b0;
    @(negedge clk); start_a[w] = 1'b0; cyc = 1;
    forever begin
      if (extra_start) start_a[w] = 1'($urandom_range(0, 1));
      if (cyc <= 32 * s && o_fn_in !== 5'((cyc - 1) / s)) r_fn_err++;
      if (held_v && (o_valid !== 1'b1 || o_index !== held_i)) r_stab_err++;
      case (rmode)
        0:       r = 1'b1;
        1:       r = cyc[0];
        default: r = 1'($urandom_range(0, 1));
      endcase
      rdy_a[w] = r;
      if (o_valid === 1'b1) begin
        r_valid_seen++;
        if (r) r_idx.push_back(int'(o_index));
        else   r_stalls++;
      end
      held_v = (o_valid === 1'b1) && !r;
      held_i = o_index;
      if (o_done === 1'b1) begin r_done_cyc = cyc; break; end
      if (cyc > 3000) begin r_timeout = 1; break; end
      @(negedge clk); cyc++;
    end
    start_a[w] = 1'b0; rdy_a[w] = 1'b0;
    @(negedge clk);
    r_busy_after = o_busy; r_done_after = o_done;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      sel = w; #1;
      checks++;
      if (o_busy !== 1'b0 || o_done !== 1'b0) begin
        errors++; $display("FAIL reset_ctrl[%0d]: busy=%b done=%b expected 0 0", w, o_busy, o_done);
      end
      checks++;
      if (o_fn_in !== 5'd0 || o_mask !== 32'd0 || o_count !== 6'd0) begin
        errors++;
        $display("FAIL reset_data[%0d]: fn_in=%0d mask=%h count=%0d expected 0", w, o_fn_in, o_mask, o_count);
      end
      checks++;
      if (o_valid !== 1'b0 || o_index !== 5'd0) begin
        errors++; $display("FAIL reset_stream[%0d]: valid=%b index=%0d expected 0 0", w, o_valid, o_index);
      end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_plan_function();
    logic [31:0] t = 32'hFFDD6AC4;
    run_scan(0, t, 0, 0, 1);
    checks++;
    if (o_mask !== t || o_count !== 6'd21) begin
      errors++; $display("FAIL plan_mask: mask=%h count=%0d expected %h 21", o_mask, o_count, t);
    end
    checks++;
    if (list_mismatch(t) != 0) begin
      errors++; $display("FAIL plan_indices: %0d differences, got %0d indices expected 21", list_mismatch(t), r_idx.size());
    end
    checks++;
    if (r_done_cyc != 65) begin
      errors++; $display("FAIL plan_done_cycle: got %0d expected 65", r_done_cyc);
    end
    checks++;
    if (r_fn_err != 0 || r_busy_after !== 1'b0 || r_done_after !== 1'b0) begin
      errors++;
      $display("FAIL plan_timing: fn_in errors=%0d busy_after=%b done_after=%b expected 0 0 0", r_fn_err, r_busy_after, r_done_after);
    end
  endtask

  task automatic test_const0();
    run_scan(0, 32'h0, 2, 0, 1);
    checks++;
    if (o_mask !== 32'h0 || o_count !== 6'd0) begin
      errors++; $display("FAIL const0_mask: mask=%h count=%0d expected 0 0", o_mask, o_count);
    end
    checks++;
    if (r_valid_seen != 0) begin
      errors++; $display("FAIL const0_valid: valid cycles=%0d expected 0", r_valid_seen);
    end
    checks++;
    if (r_done_cyc != 33) begin
      errors++; $display("FAIL const0_done_cycle: got %0d expected 33", r_done_cyc);
    end
  endtask

  task automatic test_const1_stall();
    logic [31:0] t = 32'hFFFFFFFF;
    run_scan(1, t, 1, 0, 3);
    checks++;
    if (o_mask !== t || o_count !== 6'd32) begin
      errors++; $display("FAIL const1_mask: mask=%h count=%0d expected ffffffff 32", o_mask, o_count);
    end
    checks++;
    if (list_mismatch(t) != 0) begin
      errors++; $display("FAIL const1_indices: %0d differences, got %0d indices expected 32", list_mismatch(t), r_idx.size());
    end
    checks++;
    if (r_stab_err != 0 || r_stalls == 0) begin
      errors++; $display("FAIL const1_stall: unstable=%0d stalls=%0d expected 0 and >0", r_stab_err, r_stalls);
    end
    checks++;
    if (r_done_cyc != exp_done(t, 3, r_stalls) || r_fn_err != 0) begin
      errors++;
      $display("FAIL const1_timing: done=%0d expected %0d fn_in errors=%0d", r_done_cyc, exp_done(t, 3, r_stalls), r_fn_err);
    end
  endtask

  task automatic test_random();
    logic [31:0] t;
    for (int i = 0; i < 6; i++) begin
      int w = i % 2;
      int s = (w == 1) ? 3 : 1;
      t = $urandom;
      run_scan(w, t, 2, 0, s);
      checks++;
      if (o_mask !== t || o_count !== 6'(popc(t))) begin
        errors++; $display("FAIL rand_mask[%0d]: mask=%h count=%0d expected %h %0d", i, o_mask, o_count, t, popc(t));
      end
      checks++;
      if (list_mismatch(t) != 0 || r_stab_err != 0) begin
        errors++; $display("FAIL rand_stream[%0d]: differences=%0d unstable=%0d expected 0 0", i, list_mismatch(t), r_stab_err);
      end
      checks++;
      if (r_done_cyc != exp_done(t, s, r_stalls) || r_fn_err != 0 || r_timeout) begin
        errors++;
        $display("FAIL rand_timing[%0d]: done=%0d expected %0d fn_in errors=%0d timeout=%0b", i, r_done_cyc, exp_done(t, s, r_stalls), r_fn_err, r_timeout);
      end
    end
  endtask

  task automatic test_back_to_back_start();
    logic [31:0] t = $urandom | 32'h0000_0101;
    run_scan(0, t, 0, 1, 1);
    checks++;
    if (o_mask !== t || o_count !== 6'(popc(t)) || list_mismatch(t) != 0) begin
      errors++; $display("FAIL restart_result: mask=%h count=%0d expected %h %0d", o_mask, o_count, t, popc(t));
    end
    checks++;
    if (r_done_cyc != 65 || r_fn_err != 0) begin
      errors++; $display("FAIL restart_timing: done=%0d fn_in errors=%0d expected 65 0", r_done_cyc, r_fn_err);
    end
  endtask

  task automatic test_rst_midscan();
    logic [31:0] t = $urandom | 32'h0000_01FF;
    sel = 0; truth_a[0] = t;
    @(negedge clk); start_a[0] = 1'b1;
    @(negedge clk); start_a[0] = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({o_busy, o_done, o_valid, o_index, o_fn_in, o_count} !== 18'd0 || o_mask !== 32'd0) begin
      errors++;
      $display("FAIL rst_scan_clear: busy=%b done=%b valid=%b index=%0d fn_in=%0d count=%0d mask=%h expected all 0",
               o_busy, o_done, o_valid, o_index, o_fn_in, o_count, o_mask);
    end
    rst = 1'b0;
    run_scan(0, t, 0, 0, 1);
    checks++;
    if (o_mask !== t || o_count !== 6'(popc(t)) || r_done_cyc != 65) begin
      errors++;
      $display("FAIL rst_scan_rerun: mask=%h count=%0d done=%0d expected %h %0d 65", o_mask, o_count, r_done_cyc, t, popc(t));
    end
  endtask

  task automatic test_rst_handshake();
    int  n = 0;
    int  dones = 0;
    sel = 0; truth_a[0] = $urandom | 32'h0000_0010;
    rdy_a[0] = 1'b0;
    @(negedge clk); start_a[0] = 1'b1;
    @(negedge clk); start_a[0] = 1'b0;
    while (o_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (o_valid !== 1'b1) begin
      errors++; $display("FAIL rst_hs_offer: valid=%b after %0d cycles expected 1", o_valid, n);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
      errors++; $display("FAIL rst_hs_drop: valid=%b busy=%b expected 0 0", o_valid, o_busy);
    end
    rst = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (o_done === 1'b1 || o_valid === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++; $display("FAIL rst_hs_no_done: done/valid cycles=%0d expected 0", dones);
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int w = 0; w < 2; w++) begin
      start_a[w] = 1'b0; rdy_a[w] = 1'b0; truth_a[w] = 32'h0;
    end
    test_reset();
    test_plan_function();
    test_const0();
    test_const1_stall();
    test_random();
    test_back_to_back_start();
    test_rst_midscan();
    test_rst_handshake();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
